exe_stage_pipe: RTL

//  Parametrised ARM execute stage with an integrated EX/MEM output register, an iterative

---
 rtl/exe_pkg.sv | 35 +++
 rtl/exe_stage_pipe_seq_multiplier.sv | 57 +++++
 rtl/exe_stage_pipe.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the ARM execute stage: ALU command codes, shifter
// type codes, multiply FSM states and the decoded-control bundle.
package exe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } exe_state_e;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic s_en;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/exe_stage_pipe_seq_multiplier.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per step;
// yields the low DATA_W bits of the product.
module seq_multiplier #(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hold,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int MUL_STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W     = $clog2(MUL_STEPS + 1);

  logic [DATA_W-1:0] a_q, b_q, acc_q, partial;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, step;

  assign step    = busy_q && !hold;
  assign done    = step && (cnt_q == CNT_W'(MUL_STEPS - 1));
  assign partial = a_q * DATA_W'(b_q[MUL_BITS-1:0]);
  assign product = acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a_in;
      b_q    <= b_in;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (step) begin
      acc_q <= acc_q + partial;
      a_q   <= a_q << MUL_BITS;
      b_q   <= b_q >> MUL_BITS;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// ARM execute stage with EX/MEM output register, Val2 generator, ALU with NZCV,
// branch target adder and a multi-cycle multiply sequenced by a small FSM.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int MUL_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  imm_en,
  input  logic                  s_en_in,
  input  logic                  branch_in,
  input  logic [3:0]            exe_cmd,
  input  logic [3:0]            status_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [11:0]           shifter_operand,
  input  logic [23:0]           signed_imm,
  input  logic [DATA_W-1:0]     pc,
  input  logic [DATA_W-1:0]     val_rn,
  input  logic [DATA_W-1:0]     val_rm,
  output logic                  out_valid,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic [DATA_W-1:0]     branch_addr,
  output logic [3:0]            status_out,
  output logic                  status_wr,
  output logic                  branch_taken
);

  localparam int MSB = DATA_W - 1;

  exe_state_e state_q, state_d;
  logic accept, mul_start, mul_done, is_mul, alu_load, mul_load;
  logic use_sum, inv_b, cin, ovf;
  logic [4:0] shift_amt;
  logic [DATA_W-1:0] shifted, val2, b_op, logic_res, alu_res, br_target, mul_product;
  logic [DATA_W:0] sum;
  logic [3:0] status_next;

  ctrl_t                 pend_ctrl;
  logic [REG_ADDR_W-1:0] pend_dest;
  logic [DATA_W-1:0]     pend_val_rm, pend_br;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [4:0] n);
    return (x >> n) | (x << (DATA_W - int'(n)));
  endfunction

  assign shift_amt = shifter_operand[11:7];
  assign is_mul    = (exe_cmd == EXE_MUL);
  assign in_ready  = (state_q == ST_IDLE) && !freeze;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    shifted = val_rm;
    case (shifter_operand[6:5])
      SHIFT_LSL: shifted = val_rm << shift_amt;
      SHIFT_LSR: shifted = val_rm >> shift_amt;
      SHIFT_ASR: shifted = DATA_W'($signed(val_rm) >>> shift_amt);
      SHIFT_ROR: shifted = ror(val_rm, shift_amt);
      default:   shifted = val_rm;
    endcase
    val2 = shifted;
    if (imm_en)                           val2 = ror(DATA_W'(shifter_operand[7:0]), {shifter_operand[11:8], 1'b0});
    else if (mem_r_en_in || mem_w_en_in)  val2 = DATA_W'(shifter_operand);
  end

  // Subtraction is rn + ~val2 + cin, so C out of the adder is "no borrow".
  always_comb begin
    use_sum   = 1'b0;
    inv_b     = 1'b0;
    cin       = 1'b0;
    logic_res = '0;
    case (exe_cmd)
      EXE_MOV: logic_res = val2;
      EXE_MVN: logic_res = ~val2;
      EXE_ADD: use_sum = 1'b1;
      EXE_ADC: begin use_sum = 1'b1; cin = status_in[1]; end
      EXE_SUB: begin use_sum = 1'b1; inv_b = 1'b1; cin = 1'b1; end
      EXE_SBC: begin use_sum = 1'b1; inv_b = 1'b1; cin = status_in[1]; end
      EXE_AND: logic_res = val_rn & val2;
      EXE_ORR: logic_res = val_rn | val2;
      EXE_EOR: logic_res = val_rn ^ val2;
      default: logic_res = '0;
    endcase
  end

  assign b_op    = inv_b ? ~val2 : val2;
  assign sum     = {1'b0, val_rn} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
  assign alu_res = use_sum ? sum[MSB:0] : logic_res;
  assign ovf     = (val_rn[MSB] == b_op[MSB]) && (alu_res[MSB] != val_rn[MSB]);
  // Without S the flags pass through unchanged; status_wr gates the CPSR write anyway.
  assign status_next = s_en_in ? {alu_res[MSB], alu_res == '0,
                                  use_sum ? sum[DATA_W] : status_in[1],
                                  use_sum ? ovf : status_in[0]}
                               : status_in;
  assign br_target = pc + {{(DATA_W-26){signed_imm[23]}}, signed_imm, 2'b00};

  seq_multiplier #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .hold    (freeze),
    .start   (mul_start),
    .a_in    (val_rn),
    .b_in    (val_rm),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid && !freeze && !flush) begin
        accept = 1'b1;
        if (is_mul) begin
          mul_start = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: if (mul_done) state_d = ST_DONE;
      ST_DONE: if (!freeze) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The multiply's side-band fields ride alongside it until DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_ctrl   <= '0;
      pend_dest   <= '0;
      pend_val_rm <= '0;
      pend_br     <= '0;
    end else if (mul_start) begin
      pend_ctrl   <= '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                       s_en: s_en_in, branch: branch_in};
      pend_dest   <= dest_in;
      pend_val_rm <= val_rm;
      pend_br     <= br_target;
    end
  end

  assign alu_load = accept && !is_mul;
  assign mul_load = (state_q == ST_DONE) && !freeze && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      status_wr    <= 1'b0;
      branch_taken <= 1'b0;
      dest_out     <= '0;
      alu_result   <= '0;
      val_rm_out   <= '0;
      branch_addr  <= '0;
      status_out   <= '0;
    end else if (flush || (!freeze && !alu_load && !mul_load)) begin
      out_valid    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      status_wr    <= 1'b0;
      branch_taken <= 1'b0;
    end else if (alu_load) begin
      out_valid    <= 1'b1;
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      status_wr    <= s_en_in;
      branch_taken <= branch_in;
      dest_out     <= dest_in;
      alu_result   <= alu_res;
      val_rm_out   <= val_rm;
      branch_addr  <= br_target;
      status_out   <= status_next;
    end else if (mul_load) begin
      out_valid    <= 1'b1;
      wb_en_out    <= pend_ctrl.wb_en;
      mem_r_en_out <= pend_ctrl.mem_r_en;
      mem_w_en_out <= pend_ctrl.mem_w_en;
      status_wr    <= pend_ctrl.s_en;
      branch_taken <= pend_ctrl.branch;
      dest_out     <= pend_dest;
      alu_result   <= mul_product;
      val_rm_out   <= pend_val_rm;
      branch_addr  <= pend_br;
      status_out   <= {mul_product[MSB], mul_product == '0, status_in[1:0]};
    end
  end

endmodule
